// File: rtl/rega_pkg.sv
// Shared types and default timing for the irrigation sequencer.
package rega_pkg;

    localparam int CW_DEF          = 8;
    localparam int TEMPO_ASP_DEF   = 10;
    localparam int TEMPO_GOT_DEF   = 15;
    localparam int TEMPO_PAUSA_DEF = 5;

    typedef enum logic [2:0] {
        FASE_IDLE        = 3'd0,
        FASE_ASPERSAO    = 3'd1,
        FASE_GOTEJAMENTO = 3'd2,
        FASE_PAUSA       = 3'd3,
        FASE_BLOQUEIO    = 3'd4
    } fase_t;

endpackage

// File: rtl/rega_contador.sv
// Loadable down-counter shared by every timed phase; saturates at zero.
module rega_contador #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] valor,
    input  logic          tick,
    input  logic          clr,
    output logic [CW-1:0] restante,
    output logic          ultimo
);

    logic [CW-1:0] restante_q;
    logic [CW-1:0] restante_d;

    // Next count: clear beats load beats decrement.
    always_comb begin
        restante_d = restante_q;
        if (clr) begin
            restante_d = {CW{1'b0}};
        end else if (load) begin
            restante_d = valor;
        end else if (tick && (restante_q != {CW{1'b0}})) begin
            restante_d = restante_q - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            restante_d = restante_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            restante_q <= {CW{1'b0}};
        end else begin
            restante_q <= restante_d;
        end
    end

    assign restante = restante_q;
    assign ultimo   = (restante_q == {{(CW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/rega_sequenciador.sv
// Timed irrigation-cycle controller: burst, cooldown and level-fault lockout.
// Optional manual drip start is enabled by defining REGA_MANUAL_EN.
module rega_sequenciador
    import rega_pkg::*;
#(
    parameter int TEMPO_ASP   = TEMPO_ASP_DEF,
    parameter int TEMPO_GOT   = TEMPO_GOT_DEF,
    parameter int TEMPO_PAUSA = TEMPO_PAUSA_DEF,
    parameter int CW          = CW_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          us,
    input  logic          ua,
    input  logic          t,
    input  logic          erro,
    input  logic          nv_critico,
    input  logic          nv_baixo,
`ifdef REGA_MANUAL_EN
    input  logic          manual,
`endif
    output logic          bs,
    output logic          vs,
    output logic          busy,
    output logic [2:0]    fase,
    output logic [CW-1:0] restante,
    output logic          fim_ciclo
);

    if (TEMPO_ASP < 1 || TEMPO_GOT < 1 || TEMPO_PAUSA < 1 ||
        TEMPO_ASP >= (2**CW) || TEMPO_GOT >= (2**CW) || TEMPO_PAUSA >= (2**CW)) begin : g_bad_tempo
        $error("rega_sequenciador: TEMPO_* must be in 1 .. 2**CW-1");
    end

    logic [1:0] rst_sync_q;
    logic       rst_n_s;
    fase_t      state_q, state_d;
    logic       us_prev_q, nb_prev_q;
    logic       bs_q, bs_d, vs_q, vs_d, busy_q, busy_d, fim_q, fim_d;
    logic       load_s, clr_s, cnt_tick_s, ultimo_s, fault_s, manual_s;
    logic       us_rise_s, nb_rise_s, timed_s;
    logic [CW-1:0] valor_s;

`ifdef REGA_MANUAL_EN
    assign manual_s = manual;
`else
    assign manual_s = 1'b0;
`endif

    assign fault_s   = erro | nv_critico;
    assign us_rise_s = us & ~us_prev_q;
    assign nb_rise_s = nv_baixo & ~nb_prev_q;
    assign timed_s   = (state_q == FASE_ASPERSAO) || (state_q == FASE_GOTEJAMENTO) ||
                       (state_q == FASE_PAUSA);

    // Reset goes low at once but is released on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_s = rst_sync_q[1];

    // State register plus the sensor history used for edge detection.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q   <= FASE_IDLE;
            us_prev_q <= 1'b0;
            nb_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            us_prev_q <= us;
            nb_prev_q <= nv_baixo;
        end
    end

    // Next state and counter control; faults always win.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        valor_s = {CW{1'b0}};
        case (state_q)
            FASE_IDLE: begin
                if (fault_s) begin
                    state_d = FASE_BLOQUEIO;
                end else if (manual_s || (tick && !us)) begin
                    load_s = 1'b1;
                    if (manual_s || t || !ua || nv_baixo) begin
                        state_d = FASE_GOTEJAMENTO;
                        valor_s = CW'(TEMPO_GOT);
                    end else begin
                        state_d = FASE_ASPERSAO;
                        valor_s = CW'(TEMPO_ASP);
                    end
                end else begin
                    state_d = FASE_IDLE;
                end
            end
            FASE_ASPERSAO, FASE_GOTEJAMENTO: begin
                if (fault_s) begin
                    state_d = FASE_BLOQUEIO;
                end else if (us_rise_s || (tick && ultimo_s)) begin
                    state_d = FASE_PAUSA;
                    load_s  = 1'b1;
                    valor_s = CW'(TEMPO_PAUSA);
                end else if ((state_q == FASE_ASPERSAO) && nb_rise_s) begin
                    state_d = FASE_GOTEJAMENTO;
                end else begin
                    state_d = state_q;
                end
            end
            FASE_PAUSA: begin
                if (fault_s) begin
                    state_d = FASE_BLOQUEIO;
                end else if (tick && ultimo_s) begin
                    state_d = FASE_IDLE;
                end else begin
                    state_d = FASE_PAUSA;
                end
            end
            FASE_BLOQUEIO: begin
                if (fault_s) begin
                    state_d = FASE_BLOQUEIO;
                end else begin
                    state_d = FASE_PAUSA;
                    load_s  = 1'b1;
                    valor_s = CW'(TEMPO_PAUSA);
                end
            end
            default: begin
                state_d = FASE_IDLE;
            end
        endcase
    end

    assign clr_s      = (state_d == FASE_IDLE) || (state_d == FASE_BLOQUEIO);
    assign cnt_tick_s = tick && timed_s;

    // Outputs follow the next state so they register together with it.
    always_comb begin
        bs_d   = (state_d == FASE_ASPERSAO);
        vs_d   = (state_d == FASE_GOTEJAMENTO);
        busy_d = (state_d != FASE_IDLE);
        fim_d  = ((state_q == FASE_ASPERSAO) || (state_q == FASE_GOTEJAMENTO)) &&
                 (state_d == FASE_PAUSA);
    end

    // Output registers.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            bs_q   <= 1'b0;
            vs_q   <= 1'b0;
            busy_q <= 1'b0;
            fim_q  <= 1'b0;
        end else begin
            bs_q   <= bs_d;
            vs_q   <= vs_d;
            busy_q <= busy_d;
            fim_q  <= fim_d;
        end
    end

    rega_contador #(.CW(CW)) u_contador (
        .clock    (clock),
        .rst_n    (rst_n_s),
        .load     (load_s),
        .valor    (valor_s),
        .tick     (cnt_tick_s),
        .clr      (clr_s),
        .restante (restante),
        .ultimo   (ultimo_s)
    );

    assign bs        = bs_q;
    assign vs        = vs_q;
    assign busy      = busy_q;
    assign fim_ciclo = fim_q;
    assign fase      = state_q;

endmodule

// File: tb/tb_rega_sequenciador.sv
// Self-checking bench for rega_sequenciador: directed scenarios plus random traffic
// against a cycle-level behavioural model.
module tb_rega_sequenciador;

    localparam int CW = 8;
    localparam int TA = 10;
    localparam int TG = 15;
    localparam int TP = 5;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic tick = 1'b0, us = 1'b0, ua = 1'b0, t = 1'b0;
    logic erro = 1'b0, nv_critico = 1'b0, nv_baixo = 1'b0;
    logic manual = 1'b0;
    logic bs, vs, busy, fim_ciclo;
    logic [2:0] fase;
    logic [CW-1:0] restante;

    int checks = 0;
    int errors = 0;

    // reference model: phase number, remaining ticks, end pulse, sensor history
    int m_st = 0, m_rem = 0;
    bit m_fim = 1'b0, m_us_p = 1'b0, m_nb_p = 1'b0;

    rega_sequenciador dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .tick       (tick),
        .us         (us),
        .ua         (ua),
        .t          (t),
        .erro       (erro),
        .nv_critico (nv_critico),
        .nv_baixo   (nv_baixo),
`ifdef REGA_MANUAL_EN
        .manual     (manual),
`endif
        .bs         (bs),
        .vs         (vs),
        .busy       (busy),
        .fase       (fase),
        .restante   (restante),
        .fim_ciclo  (fim_ciclo)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_rem = 0; m_fim = 1'b0; m_us_p = 1'b0; m_nb_p = 1'b0;
    endtask

    // One clock of the controller rules, from the inputs sampled at the edge.
    task automatic model_step();
        bit fault, man, us_r, nb_r;
        fault = erro | nv_critico;
`ifdef REGA_MANUAL_EN
        man = manual;
`else
        man = 1'b0;
`endif
        us_r = us & ~m_us_p;
        nb_r = nv_baixo & ~m_nb_p;
        m_fim = 1'b0;
        if (fault) begin
            m_st = 4; m_rem = 0;
        end else if (m_st == 0) begin
            if (man) begin
                m_st = 2; m_rem = TG;
            end else if (tick && !us) begin
                if (t || !ua || nv_baixo) begin m_st = 2; m_rem = TG; end
                else begin m_st = 1; m_rem = TA; end
            end
        end else if (m_st == 1 || m_st == 2) begin
            if (us_r || (tick && m_rem == 1)) begin
                m_st = 3; m_rem = TP; m_fim = 1'b1;
            end else begin
                if (tick && m_rem > 0) m_rem--;
                if (m_st == 1 && nb_r) m_st = 2;
            end
        end else if (m_st == 3) begin
            if (tick) begin
                if (m_rem == 1) begin m_st = 0; m_rem = 0; end
                else m_rem--;
            end
        end else begin
            m_st = 3; m_rem = TP;
        end
        m_us_p = us;
        m_nb_p = nv_baixo;
    endtask

    task automatic compare_all();
        check_eq("fase", 32'(fase), 32'(m_st));
        check_eq("restante", 32'(restante), 32'(m_rem));
        check_eq("bs", 32'(bs), 32'(m_st == 1));
        check_eq("vs", 32'(vs), 32'(m_st == 2));
        check_eq("busy", 32'(busy), 32'(m_st != 0));
        check_eq("fim_ciclo", 32'(fim_ciclo), 32'(m_fim));
        check_eq("bs_vs_excl", 32'(bs & vs), 32'd0);
    endtask

    // Inputs are already driven; advance one edge and compare with the model.
    task automatic step();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit tk, input bit s_us, input bit s_ua, input bit s_t,
                          input bit s_er, input bit s_nc, input bit s_nb);
        tick = tk; us = s_us; ua = s_ua; t = s_t;
        erro = s_er; nv_critico = s_nc; nv_baixo = s_nb;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        for (int i = 0; i < n; i++) step();
        tick = 1'b0;
    endtask

    task automatic release_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        manual = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
    endtask

    initial begin
        model_reset();
        #1;
        check_eq("rst_bs", 32'(bs), 32'd0);
        check_eq("rst_fase", 32'(fase), 32'd0);
        check_eq("rst_restante", 32'(restante), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        release_reset();

        // aspersion burst, cooldown, back to idle
        set_in(1, 0, 1, 0, 0, 0, 0);
        step();
        check_eq("asp_start_bs", 32'(bs), 32'd1);
        ticks(TA);
        check_eq("asp_end_fim", 32'(fim_ciclo), 32'd1);
        check_eq("asp_end_fase", 32'(fase), 32'd3);
        check_eq("asp_end_rest", 32'(restante), 32'(TP));
        ticks(TP);
        check_eq("pausa_end_fase", 32'(fase), 32'd0);

        // drip burst ended early by soil getting wet
        set_in(1, 0, 1, 1, 0, 0, 0);
        step();
        check_eq("got_start_vs", 32'(vs), 32'd1);
        ticks(5);
        set_in(1, 1, 1, 1, 0, 0, 0);
        step();
        check_eq("early_vs", 32'(vs), 32'd0);
        check_eq("early_fim", 32'(fim_ciclo), 32'd1);
        check_eq("early_rest", 32'(restante), 32'(TP));
        tick = 1'b0;
        step();
        check_eq("early_single_fim", 32'(fim_ciclo), 32'd0);
        ticks(TP + 2);
        check_eq("wet_idle", 32'(fase), 32'd0);

        // low level during aspersion switches to drip keeping the count
        set_in(1, 0, 1, 0, 0, 0, 0);
        step();
        ticks(3);
        check_eq("pre_switch_rest", 32'(restante), 32'd7);
        set_in(1, 0, 1, 0, 0, 0, 1);
        step();
        check_eq("switch_bs", 32'(bs), 32'd0);
        check_eq("switch_vs", 32'(vs), 32'd1);
        check_eq("switch_rest", 32'(restante), 32'd6);

        // critical level together with a tick during drip
        set_in(1, 0, 1, 0, 0, 1, 1);
        step();
        check_eq("crit_fase", 32'(fase), 32'd4);
        check_eq("crit_vs", 32'(vs), 32'd0);
        check_eq("crit_fim", 32'(fim_ciclo), 32'd0);
        set_in(0, 0, 1, 0, 0, 0, 0);
        step();
        check_eq("recover_fase", 32'(fase), 32'd3);
        check_eq("recover_rest", 32'(restante), 32'(TP));
        ticks(TP);
        check_eq("recover_idle", 32'(fase), 32'd0);

        // reset asserted mid-aspersion at restante=4
        set_in(1, 0, 1, 0, 0, 0, 0);
        step();
        ticks(6);
        check_eq("pre_reset_rest", 32'(restante), 32'd4);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("async_rst_bs", 32'(bs), 32'd0);
        check_eq("async_rst_fase", 32'(fase), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        release_reset();
        step();
        check_eq("post_rst_fase", 32'(fase), 32'd0);

`ifdef REGA_MANUAL_EN
        set_in(0, 1, 1, 0, 0, 0, 0);
        manual = 1'b1;
        step();
        manual = 1'b0;
        check_eq("man_vs", 32'(vs), 32'd1);
        check_eq("man_rest", 32'(restante), 32'(TG));
        ticks(TG);
        check_eq("man_end_fase", 32'(fase), 32'd3);
        ticks(TP);
        set_in(0, 1, 1, 0, 1, 0, 0);
        step();
        manual = 1'b1;
        step();
        manual = 1'b0;
        check_eq("man_blocked", 32'(fase), 32'd4);
        set_in(0, 1, 1, 0, 0, 0, 0);
        step();
        ticks(TP);
`endif

        // random traffic with slowly changing sensors and rare faults
        for (int i = 0; i < 3000; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 15) == 0) us = ~us;
            if ($urandom_range(0, 7) == 0) ua = ~ua;
            if ($urandom_range(0, 7) == 0) t = ~t;
            if ($urandom_range(0, 20) == 0) nv_baixo = ~nv_baixo;
            erro = ($urandom_range(0, 60) == 0) ? ~erro : erro;
            nv_critico = ($urandom_range(0, 80) == 0) ? ~nv_critico : nv_critico;
`ifdef REGA_MANUAL_EN
            manual = ($urandom_range(0, 30) == 0);
`endif
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
